// File: rtl/demux1ne6_if.sv
// Bus bundle for the 1-to-6 demultiplexer with per-channel holding registers.
// master = producer/consumer side (testbench), slave = the demux itself.
interface demux1ne6_if #(
  parameter int W = 16
);
  logic [W-1:0] hyrja;
  logic [2:0]   s;
  logic         hyrja_valid;
  logic         hyrja_ready;
  logic [W-1:0] dalja [6];
  logic [5:0]   dalja_valid;
  logic [5:0]   dalja_ready;
  logic         gabim;
  logic [7:0]   nr_gabimeve;

  modport master (
    output hyrja, s, hyrja_valid, dalja_ready,
    input  hyrja_ready, dalja, dalja_valid, gabim, nr_gabimeve
  );

  modport slave (
    input  hyrja, s, hyrja_valid, dalja_ready,
    output hyrja_ready, dalja, dalja_valid, gabim, nr_gabimeve
  );
endinterface

// File: rtl/demux1ne6_reg.sv
// 1-to-6 demultiplexer: each output channel is a one-entry buffer
// (holding register + valid bit). Selects 6 and 7 are illegal; such words are
// accepted and dropped, setting a sticky error flag and a saturating counter.
module demux1ne6_reg #(
  parameter int W = 16
) (
  input logic          i_clock,
  input logic          i_reset,
  demux1ne6_if.slave   bus
);

  logic [W-1:0] r_dalja [6];
  logic [5:0]   r_valid;
  logic         r_gabim;
  logic [7:0]   r_nr_gabimeve;

  logic [7:0]   w_busy;
  logic         w_illegal;
  logic         w_ready;
  logic         w_xfer;
  logic [5:0]   w_load;
  logic [5:0]   w_drain;

  // Ready/transfer decode; illegal selects index the zero-padded upper bits,
  // so they always see a free slot.
  always_comb begin
    w_busy    = {2'b00, r_valid & ~bus.dalja_ready};
    w_illegal = (bus.s > 3'd5);
    w_ready   = i_reset & ~w_busy[bus.s];
    w_xfer    = bus.hyrja_valid & w_ready;
    w_drain   = r_valid & bus.dalja_ready;
    w_load    = '0;
    for (int k = 0; k < 6; k++) begin
      if (w_xfer && !w_illegal && (bus.s == 3'(k))) w_load[k] = 1'b1;
    end
  end

  // Channel buffers and error bookkeeping; a load wins over a drain so a
  // simultaneous drain+load keeps the channel full with the new word.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int k = 0; k < 6; k++) r_dalja[k] <= '0;
      r_valid       <= '0;
      r_gabim       <= 1'b0;
      r_nr_gabimeve <= '0;
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (w_load[k]) begin
          r_dalja[k] <= bus.hyrja;
          r_valid[k] <= 1'b1;
        end else if (w_drain[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
      if (w_xfer && w_illegal) begin
        r_gabim <= 1'b1;
        if (r_nr_gabimeve != 8'hFF) r_nr_gabimeve <= r_nr_gabimeve + 8'd1;
      end
    end
  end

  assign bus.hyrja_ready = w_ready;
  assign bus.dalja       = r_dalja;
  assign bus.dalja_valid = r_valid;
  assign bus.gabim       = r_gabim;
  assign bus.nr_gabimeve = r_nr_gabimeve;

endmodule

// File: doc/demux1ne6_reg.md
DEMUX1NE6_REG -- requirements
Module: demux1ne6_reg

Interface
REQ-001: Parameter W, default 16, data width of input and each output channel.
REQ-002: Clock  in  1  single clock; all state updates on rising edge.
REQ-003: Reset  in  1  synchronous, active-low reset; sampled on rising edge of Clock.
REQ-004: Hyrja  in  W  input data word.
REQ-005: S  in  3  destination select; 0..5 legal, 6..7 illegal.
REQ-006: HyrjaValid  in  1  input word and S valid this cycle.
REQ-007: HyrjaReady  out  1  block accepts the input word this cycle.
REQ-008: Dalja0..Dalja5  out  W each  channel holding-register data.
REQ-009: DaljaValid  out  6  bit k set = Dalja<k> holds an undelivered word.
REQ-010: DaljaReady  in  6  bit k set = consumer k takes Dalja<k> this cycle.
REQ-011: Gabim  out  1  sticky flag; an illegal-select word was accepted.
REQ-012: NrGabimeve  out  8  saturating count of accepted illegal-select words.

Function
REQ-013: Each channel SHALL have one W-bit holding register and a valid bit, i.e. a one-entry buffer.
REQ-014: Input transfer SHALL occur when HyrjaValid=1 and HyrjaReady=1 on the same rising edge.
REQ-015: With S<=5, HyrjaReady SHALL equal (!DaljaValid[S] | DaljaReady[S]); it is combinational from S, DaljaValid and DaljaReady.
REQ-016: With S in {6,7}, HyrjaReady SHALL be 1; the word is dropped.
REQ-017: With Reset=0, HyrjaReady SHALL be 0.
REQ-018: On a transfer with S=k<=5, Dalja<k> SHALL load Hyrja and DaljaValid[k] SHALL be 1 in the next cycle (latency 1).
REQ-019: A channel drains when DaljaValid[k]=1 and DaljaReady[k]=1; with no simultaneous load to k, DaljaValid[k] SHALL clear next cycle.
REQ-020: If a channel drains and loads in the same cycle, DaljaValid[k] SHALL remain 1 and Dalja<k> SHALL take the new word (no bubble, no loss).
REQ-021: A full channel (DaljaValid=1, DaljaReady=0) selected by S SHALL hold HyrjaReady=0; no state SHALL change for that channel or for the counters.
REQ-022: Dalja<k> SHALL hold its value until the next load, including after a drain.
REQ-023: Loads and drains on channels other than S SHALL proceed independently in the same cycle.
REQ-024: DaljaReady[k] while DaljaValid[k]=0 SHALL have no effect.
REQ-025: On a transfer with S in {6,7}, Gabim SHALL set to 1 next cycle and stay 1 until reset.
REQ-026: On the same transfer, NrGabimeve SHALL increment by 1 and saturate at 255 (no wrap).
REQ-027: A blocked input (HyrjaValid=1, HyrjaReady=0) SHALL leave all state unchanged.

Reset
REQ-028: Reset=0 at a rising edge SHALL clear Dalja0..Dalja5 to 0, DaljaValid to 6'b0, Gabim to 0 and NrGabimeve to 0.
REQ-029: Reset SHALL take priority over any simultaneous transfer or drain.
REQ-030: Reset asserted mid-operation SHALL discard buffered words; no DaljaValid bit SHALL be set in the first cycle after reset release.

Verification
REQ-031: Reset low 2 cycles -> all outputs 0, HyrjaReady=0; release with S=3 and HyrjaValid=0 -> HyrjaReady=1.
REQ-032: Hyrja=16'hA5A5, S=2, HyrjaValid=1, DaljaReady=0 -> next cycle Dalja2=16'hA5A5, DaljaValid=6'b000100; a second word to S=2 sees HyrjaReady=0, Dalja2 unchanged.
REQ-033: Channel 2 full, DaljaReady[2]=1, Hyrja=16'h1234, S=2 -> HyrjaReady=1; next cycle Dalja2=16'h1234, DaljaValid[2]=1.
REQ-034: Same cycle: load S=0 with 16'h0001 and drain channel 5 (full, DaljaReady[5]=1) -> DaljaValid[0]=1, DaljaValid[5]=0, Dalja5 retains its old value.
REQ-035: 300 consecutive transfers with S=7 -> Gabim=1, NrGabimeve=255, DaljaValid=0, HyrjaReady=1 throughout.
REQ-036: Channel 4 loaded, then Reset low for 1 cycle with a simultaneous transfer to S=4 -> DaljaValid=0 and Dalja4=0 after the edge.
